calc_alu_sequencer: RTL and testbench

Multi-cycle arithmetic sequencer for the calculator datapath. It takes binary operands from the BCD front-end conversion and an opcode, then sequences one shared W+1-bit adder. Addition and subtraction complete in one step; shift-add multiply and restoring divide each take W steps. Results and status flags are returned through a start/busy/done handshake. It replaces the single-cycle `+ - * / %` operators in the calculator top level, and its outputs feed the BIN2BCD result and remainder converters.

---
 rtl/calc_alu_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_calc_alu_sequencer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/calc_alu_sequencer.sv
// Multi-cycle arithmetic sequencer: add/sub in one step, shift-add multiply and
// restoring divide in WIDTH steps, all through one shared WIDTH+1-bit adder.
module calc_alu_sequencer #(
  parameter int unsigned WIDTH = 24
) (
  input  logic             iCLK,
  input  logic             iRST_n,
  input  logic             iSTART,
  input  logic             iCLR,
  input  logic [1:0]       iOP,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  output logic             oBUSY,
  output logic             oDONE,
  output logic [WIDTH-1:0] oRESULT,
  output logic [WIDTH-1:0] oREMAINDER,
  output logic             oOVF,
  output logic             oDIVZ
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  localparam logic [1:0] OpDiv = 2'b00;
  localparam logic [1:0] OpAdd = 2'b01;
  localparam logic [1:0] OpSub = 2'b10;
  localparam logic [1:0] OpMul = 2'b11;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q;
  logic [1:0]        op_q;
  logic [WIDTH-1:0]  a_q;    // addend / multiplicand
  logic [WIDTH-1:0]  b_q;    // addend / shifting multiplier / divisor
  logic [WIDTH-1:0]  acc_q;  // product upper half / partial remainder
  logic [WIDTH-1:0]  lo_q;   // product lower half / dividend shifting into quotient
  logic [CntW-1:0]   cnt_q;
  logic              busy_q, done_q, ovf_q, divz_q;
  logic [WIDTH-1:0]  result_q, rem_q;

  logic [WIDTH:0]    add_x, add_y;
  logic              add_cin;
  logic [WIDTH+1:0]  add_sum;
  logic              carry;
  logic [WIDTH-1:0]  mul_hi_n, mul_lo_n, div_rem_n, div_lo_n;

  // Shared adder operand multiplexing and per-op step results.
  always_comb begin
    add_x   = '0;
    add_y   = '0;
    add_cin = 1'b0;
    case (op_q)
      OpAdd: begin
        add_x = {1'b0, a_q};
        add_y = {1'b0, b_q};
      end
      OpSub: begin
        add_x   = {1'b0, a_q};
        add_y   = {1'b1, ~b_q};
        add_cin = 1'b1;
      end
      OpMul: begin
        add_x = {1'b0, acc_q};
        add_y = b_q[0] ? {1'b0, a_q} : '0;
      end
      default: begin
        // Shifted partial remainder needs WIDTH+1 bits before the trial subtract.
        add_x   = {acc_q, lo_q[WIDTH-1]};
        add_y   = {1'b1, ~b_q};
        add_cin = 1'b1;
      end
    endcase
    add_sum   = {1'b0, add_x} + {1'b0, add_y} + {{(WIDTH + 1){1'b0}}, add_cin};
    // Carry out of the WIDTH+1-bit adder means no borrow for sub/div.
    carry     = add_sum[WIDTH+1];
    mul_hi_n  = add_sum[WIDTH:1];
    mul_lo_n  = {add_sum[0], lo_q[WIDTH-1:1]};
    div_rem_n = carry ? add_sum[WIDTH-1:0] : add_x[WIDTH-1:0];
    div_lo_n  = {lo_q[WIDTH-2:0], carry};
  end

  // Sequencer FSM, working registers and registered outputs.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q  <= StIdle;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      lo_q     <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      rem_q    <= '0;
      ovf_q    <= 1'b0;
      divz_q   <= 1'b0;
    end else if (iCLR) begin
      state_q <= StIdle;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          if (iSTART) begin
            op_q    <= iOP;
            a_q     <= iA;
            b_q     <= iB;
            acc_q   <= '0;
            lo_q    <= (iOP == OpDiv) ? iA : '0;
            cnt_q   <= ((iOP == OpMul) || ((iOP == OpDiv) && (iB != '0))) ? CntLast : '0;
            busy_q  <= 1'b1;
            state_q <= StRun;
          end
        end
        StRun: begin
          if (op_q == OpMul) begin
            acc_q <= mul_hi_n;
            lo_q  <= mul_lo_n;
            b_q   <= b_q >> 1;
          end else if ((op_q == OpDiv) && (b_q != '0)) begin
            acc_q <= div_rem_n;
            lo_q  <= div_lo_n;
          end
          if (cnt_q == '0) begin
            case (op_q)
              OpAdd: begin
                result_q <= add_sum[WIDTH-1:0];
                rem_q    <= '0;
                ovf_q    <= add_sum[WIDTH];
                divz_q   <= 1'b0;
              end
              OpSub: begin
                result_q <= add_sum[WIDTH-1:0];
                rem_q    <= '0;
                ovf_q    <= ~carry;
                divz_q   <= 1'b0;
              end
              OpMul: begin
                result_q <= mul_lo_n;
                rem_q    <= '0;
                ovf_q    <= |mul_hi_n;
                divz_q   <= 1'b0;
              end
              default: begin
                if (b_q == '0) begin
                  result_q <= '0;
                  rem_q    <= a_q;
                  divz_q   <= 1'b1;
                end else begin
                  result_q <= div_lo_n;
                  rem_q    <= div_rem_n;
                  divz_q   <= 1'b0;
                end
                ovf_q <= 1'b0;
              end
            endcase
            done_q  <= 1'b1;
            state_q <= StDone;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign oBUSY      = busy_q;
  assign oDONE      = done_q;
  assign oRESULT    = result_q;
  assign oREMAINDER = rem_q;
  assign oOVF       = ovf_q;
  assign oDIVZ      = divz_q;

endmodule

// File: tb/tb_calc_alu_sequencer.sv
// Scoreboard bench for calc_alu_sequencer: stimulus pushes expected results,
// a negedge monitor pops and compares whenever oDONE is seen.
module tb_calc_alu_sequencer;

  localparam int W = 24;

  logic         iCLK = 1'b0;
  logic         iRST_n = 1'b0;
  logic         iSTART = 1'b0;
  logic         iCLR = 1'b0;
  logic [1:0]   iOP = 2'b00;
  logic [W-1:0] iA = '0;
  logic [W-1:0] iB = '0;
  logic         oBUSY, oDONE, oOVF, oDIVZ;
  logic [W-1:0] oRESULT, oREMAINDER;

  typedef struct packed {
    logic [W-1:0] res;
    logic [W-1:0] rem;
    logic         ovf;
    logic         divz;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;

  calc_alu_sequencer #(.WIDTH(W)) dut (
    .iCLK      (iCLK),
    .iRST_n    (iRST_n),
    .iSTART    (iSTART),
    .iCLR      (iCLR),
    .iOP       (iOP),
    .iA        (iA),
    .iB        (iB),
    .oBUSY     (oBUSY),
    .oDONE     (oDONE),
    .oRESULT   (oRESULT),
    .oREMAINDER(oREMAINDER),
    .oOVF      (oOVF),
    .oDIVZ     (oDIVZ)
  );

  always #5 iCLK = ~iCLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compare every completed operation against the scoreboard head.
  always @(negedge iCLK) begin
    if (iRST_n && oDONE) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 32'(oDONE), 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("result", 32'(oRESULT), 32'(e.res));
        check("remainder", 32'(oREMAINDER), 32'(e.rem));
        check("ovf", 32'(oOVF), 32'(e.ovf));
        check("divz", 32'(oDIVZ), 32'(e.divz));
      end
    end
  end

  // Drive a start request; returns 1 time unit after the accept edge.
  task automatic launch(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge iCLK);
    iOP = op; iA = a; iB = b; iSTART = 1'b1;
    @(posedge iCLK);
    #1;
    iSTART = 1'b0;
  endtask

  // Full transaction with latency and handshake checks; optional start poke mid-run.
  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] res, input logic [W-1:0] rem, input logic ovf,
                       input logic divz, input int n, input int poke_edge);
    exp_t e;
    int   got;
    e = '{res: res, rem: rem, ovf: ovf, divz: divz};
    sb_q.push_back(e);
    launch(op, a, b);
    check("busy_rise", 32'(oBUSY), 32'd1);
    got = -1;
    for (int k = 1; k <= n + 5; k++) begin
      @(posedge iCLK);
      #1;
      iSTART = 1'b0;
      if (oDONE) begin
        got = k;
        break;
      end
      if (k == poke_edge) begin
        iSTART = 1'b1; iOP = 2'b01; iA = 24'd1; iB = 24'd1;
      end
    end
    check("done_latency", 32'(got), 32'(n));
    @(posedge iCLK);
    #1;
    check("done_pulse_end", 32'(oDONE), 32'd0);
    check("busy_fall", 32'(oBUSY), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #12;
    check("rst_busy", 32'(oBUSY), 32'd0);
    check("rst_done", 32'(oDONE), 32'd0);
    check("rst_result", 32'(oRESULT), 32'd0);
    check("rst_rem", 32'(oREMAINDER), 32'd0);
    check("rst_ovf", 32'(oOVF), 32'd0);
    check("rst_divz", 32'(oDIVZ), 32'd0);
    @(negedge iCLK);
    iRST_n = 1'b1;

    // Add / sub
    issue(2'b01, 24'd999999, 24'd1, 24'h0F4240, 24'd0, 1'b0, 1'b0, 1, 0);
    issue(2'b10, 24'd5, 24'd7, 24'hFFFFFE, 24'd0, 1'b1, 1'b0, 1, 0);
    issue(2'b01, 24'hFFFFFF, 24'd1, 24'd0, 24'd0, 1'b1, 1'b0, 1, 0);
    issue(2'b10, 24'd7, 24'd5, 24'd2, 24'd0, 1'b0, 1'b0, 1, 0);

    // Mul
    issue(2'b11, 24'd999, 24'd999, 24'd998001, 24'd0, 1'b0, 1'b0, W, 0);
    issue(2'b11, 24'd4096, 24'd4096, 24'd0, 24'd0, 1'b1, 1'b0, W, 0);

    // Div
    issue(2'b00, 24'd1000000, 24'd7, 24'd142857, 24'd1, 1'b0, 1'b0, W, 0);
    issue(2'b00, 24'd123, 24'd0, 24'd0, 24'd123, 1'b0, 1'b1, 1, 0);
    issue(2'b00, 24'd5, 24'd9, 24'd0, 24'd5, 1'b0, 1'b0, W, 0);

    // Start pulsed during a mul run is ignored
    issue(2'b11, 24'd12, 24'd13, 24'd156, 24'd0, 1'b0, 1'b0, W, 5);
    repeat (4) @(posedge iCLK);
    #1;
    check("poke_not_queued", 32'(oBUSY), 32'd0);

    // Clear at edge 10 of a div: no done, outputs retained
    launch(2'b00, 24'd1000000, 24'd7);
    repeat (9) @(posedge iCLK);
    #1;
    iCLR = 1'b1;
    @(posedge iCLK);
    #1;
    iCLR = 1'b0;
    check("clr_busy", 32'(oBUSY), 32'd0);
    check("clr_done", 32'(oDONE), 32'd0);
    repeat (30) @(posedge iCLK);
    #1;
    check("clr_busy_later", 32'(oBUSY), 32'd0);
    check("clr_keep_result", 32'(oRESULT), 32'd156);
    check("clr_keep_ovf", 32'(oOVF), 32'd0);

    // Clear together with start in IDLE: start dropped
    @(negedge iCLK);
    iOP = 2'b01; iA = 24'd1; iB = 24'd2; iSTART = 1'b1; iCLR = 1'b1;
    @(posedge iCLK);
    #1;
    iSTART = 1'b0; iCLR = 1'b0;
    check("clr_start_busy", 32'(oBUSY), 32'd0);
    repeat (2) @(posedge iCLK);
    #1;
    check("clr_start_busy2", 32'(oBUSY), 32'd0);

    // Asynchronous reset mid-div
    launch(2'b00, 24'd1000000, 24'd7);
    repeat (5) @(posedge iCLK);
    #3;
    iRST_n = 1'b0;
    #1;
    check("arst_busy", 32'(oBUSY), 32'd0);
    check("arst_done", 32'(oDONE), 32'd0);
    check("arst_result", 32'(oRESULT), 32'd0);
    check("arst_rem", 32'(oREMAINDER), 32'd0);
    check("arst_ovf", 32'(oOVF), 32'd0);
    check("arst_divz", 32'(oDIVZ), 32'd0);
    @(negedge iCLK);
    iRST_n = 1'b1;
    repeat (2) @(posedge iCLK);
    issue(2'b01, 24'd2, 24'd3, 24'd5, 24'd0, 1'b0, 1'b0, 1, 0);

    repeat (3) @(posedge iCLK);
    check("scoreboard_drain", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
